// File: rtl/sys_cntr_pkg.sv
// Shared definitions for the system-controller receive path: command codes,
// decoder state encoding and the fixed ALU operand register addresses.
package sys_cntr_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_WR      = 8'hAA;  // write: addr, data
    localparam logic [7:0] CMD_RD      = 8'hBB;  // read: addr
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // ALU with operands: A, B, fun
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU without operands: fun

    // Register-file slots that hold the ALU operands
    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    // Frame parser states
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_ADDR   = 4'd1,
        WR_DATA   = 4'd2,
        RD_ADDR   = 4'd3,
        RD_WAIT   = 4'd4,
        OP_A      = 4'd5,
        OP_B      = 4'd6,
        ALU_FUN_S = 4'd7,
        ALU_WAIT  = 4'd8
    } state_e;

endpackage

// File: rtl/sys_cntr_rx_decoder_wait_timer.sv
// Clearable saturating cycle counter used to bound the decoder's wait states.
// expired is high once the count has reached WAIT_MAX and stays high until cleared.
module wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear wins over counting; counting stops at the limit
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it is just the highest-priority branch, not in the sensitivity list.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sys_cntr_rx_decoder.sv
// Receive-side command decoder of the system controller. Parses multi-byte
// frames from the UART receiver, drives register-file writes/reads and ALU
// starts, then waits (with a timeout) for the read/ALU result before taking
// the next frame. All outputs are registered.
module sys_cntr_rx_decoder
    import sys_cntr_pkg::*;
#(
    parameter int width      = 8,
    parameter int addr_width = 4,
    parameter int WAIT_MAX   = 255
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [width-1:0]      Rx_Data,
    input  logic                  Rx_valid,
    input  logic                  Rd_valid,
    input  logic                  ALU_out_valid,
    output logic [addr_width-1:0] Address,
    output logic                  WrEn,
    output logic [width-1:0]      WrData,
    output logic                  RdEn,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  Gate_EN,
    output logic                  Cmd_error
);

    state_e                  state_d,    state_q;
    logic [addr_width-1:0]   wr_addr_d,  wr_addr_q;
    logic [addr_width-1:0]   address_d,  address_q;
    logic [width-1:0]        wr_data_d,  wr_data_q;
    logic                    wr_en_d,    wr_en_q;
    logic                    rd_en_d,    rd_en_q;
    logic                    alu_en_d,   alu_en_q;
    logic [3:0]              alu_fun_d,  alu_fun_q;
    logic                    gate_en_d,  gate_en_q;
    logic                    cmd_err_d,  cmd_err_q;

    logic                    tmr_clr;
    logic                    tmr_en;
    logic                    tmr_expired;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (Reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Frame parser: next state and next value of every registered output
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        cmd_err_d = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Rx_valid) begin
                    case (Rx_Data)
                        width'(CMD_WR):      state_d = WR_ADDR;
                        width'(CMD_RD):      state_d = RD_ADDR;
                        width'(CMD_ALU_OP):  state_d = OP_A;
                        width'(CMD_ALU_NOP): state_d = ALU_FUN_S;
                        default:             cmd_err_d = 1'b1;
                    endcase
                end
            end
            WR_ADDR: begin
                // Address is held privately so the port only moves with WrEn
                if (Rx_valid) begin
                    wr_addr_d = Rx_Data[addr_width-1:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (Rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = wr_addr_q;
                    wr_data_d = Rx_Data;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (Rx_valid) begin
                    rd_en_d   = 1'b1;
                    address_d = Rx_Data[addr_width-1:0];
                    tmr_clr   = 1'b1;
                    state_d   = RD_WAIT;
                end
            end
            OP_A: begin
                if (Rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_width'(OPA_ADDR);
                    wr_data_d = Rx_Data;
                    state_d   = OP_B;
                end
            end
            OP_B: begin
                if (Rx_valid) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_width'(OPB_ADDR);
                    wr_data_d = Rx_Data;
                    state_d   = ALU_FUN_S;
                end
            end
            ALU_FUN_S: begin
                if (Rx_valid) begin
                    alu_fun_d = Rx_Data[3:0];
                    alu_en_d  = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            RD_WAIT, ALU_WAIT: begin
                // Bytes arriving while a result is pending are dropped and flagged;
                // the awaited valid takes priority over the timeout.
                tmr_en = 1'b1;
                if (Rx_valid) begin
                    cmd_err_d = 1'b1;
                end
                if ((state_q == RD_WAIT) ? Rd_valid : ALU_out_valid) begin
                    state_d = IDLE;
                end else if (tmr_expired) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clock gate tracks the state being registered, so it is high exactly in the ALU states
        gate_en_d = (state_d == ALU_FUN_S) || (state_d == ALU_WAIT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            address_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            gate_en_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            alu_fun_q <= alu_fun_d;
            gate_en_q <= gate_en_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign Address   = address_q;
    assign WrEn      = wr_en_q;
    assign WrData    = wr_data_q;
    assign RdEn      = rd_en_q;
    assign ALU_EN    = alu_en_q;
    assign ALU_FUN   = alu_fun_q;
    assign Gate_EN   = gate_en_q;
    assign Cmd_error = cmd_err_q;

endmodule

// File: doc/sys_cntr_rx_decoder.md
# sys_cntr_rx_decoder

Command decoder on the receive side of the system controller. It consumes synchronized bytes from the UART receiver and parses multi-byte command frames. It then drives the register file (write/read) and the ALU (operands, function, enable, clock-gate enable). It waits for `Rd_valid` or `ALU_out_valid`, which go to the Tx-side controller, before it accepts the next frame.

## Interface
- `width`, 8, data/byte width
- `addr_width`, 4, register-file address width
- `WAIT_MAX`, 255, cycles allowed in a wait state before timeout
- `CLK` in 1: single clock
- `Reset` in 1: synchronous, active-low; all state/outputs cleared on the CLK edge where `Reset`=0
- `Rx_Data` in width: received byte, valid only with `Rx_valid`
- `Rx_valid` in 1: one-cycle pulse per byte
- `Rd_valid` in 1: register file read data valid
- `ALU_out_valid` in 1: ALU result valid
- `Address` out addr_width: register-file address
- `WrEn` out 1: one-cycle write pulse
- `WrData` out width: write data
- `RdEn` out 1: one-cycle read pulse
- `ALU_EN` out 1: one-cycle ALU start pulse
- `ALU_FUN` out 4: ALU function, held until next ALU command
- `Gate_EN` out 1: ALU clock-gate enable
- `Cmd_error` out 1: one-cycle pulse on illegal command, dropped byte or timeout

## Operation
- Command codes: `0xAA` write (addr, data); `0xBB` read (addr); `0xCC` ALU with operands (A, B, fun); `0xDD` ALU no operands (fun).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT.
- IDLE + byte: AA→WR_ADDR, BB→RD_ADDR, CC→OP_A, DD→ALU_FUN_S. Any other byte pulses `Cmd_error` and stays in IDLE.
- WR_ADDR: latch `Rx_Data[addr_width-1:0]` → WR_DATA. WR_DATA: `WrEn`=1 with latched `Address`, `WrData`=byte → IDLE.
- RD_ADDR: `RdEn`=1, `Address`=byte → RD_WAIT. RD_WAIT: `Rd_valid`→IDLE.
- OP_A: `WrEn`, `Address`=0, `WrData`=byte → OP_B. OP_B: same with `Address`=1 → ALU_FUN_S.
- ALU_FUN_S: `ALU_FUN`=byte[3:0], `ALU_EN`=1 → ALU_WAIT. ALU_WAIT: `ALU_out_valid`→IDLE.
- `Gate_EN`=1 exactly while the state is ALU_FUN_S or ALU_WAIT.
- RD_WAIT/ALU_WAIT: a `Rx_valid` byte is dropped and pulses `Cmd_error`.
- Timeout counter is cleared on entry to RD_WAIT/ALU_WAIT and increments each cycle there. On reaching `WAIT_MAX` without the valid input: `Cmd_error` pulse → IDLE.
- Mid-frame states (WR_ADDR…ALU_FUN_S) have no timeout and wait indefinitely for the next byte.
- `Rx_valid` and the awaited valid input in the same cycle: the valid input wins (→IDLE) and the byte is dropped with `Cmd_error`.

## Timing
- All outputs are registered. The response appears on the edge after the accepting `Rx_valid` cycle (1-cycle latency).
- `WrEn`/`RdEn`/`ALU_EN`/`Cmd_error` are high exactly one cycle. `Address`/`WrData` hold their value until the next update.
- `Gate_EN` rises on the edge entering ALU_FUN_S. It is therefore high at least one cycle before `ALU_EN`. It falls on the edge after `ALU_out_valid` or after the timeout.
- Reset values: state IDLE, counter 0, every output 0 (`ALU_FUN`=0).
- Reset mid-frame abandons the frame with no write/read/ALU pulse. The next frame is parsed from its command byte.
- Back-to-back bytes (`Rx_valid` every cycle) are accepted in all non-wait states.

## Structure
- Shared package `sys_cntr_pkg`: command codes (`CMD_WR`, `CMD_RD`, `CMD_ALU_OP`, `CMD_ALU_NOP`), state encoding, operand addresses (`OPA_ADDR`=0, `OPB_ADDR`=1).
- One sub-module, `wait_timer`, holds the clearable saturating counter and produces `expired` at `WAIT_MAX`.
- FSM and output registers live in the top module.

## Test plan
- Frame AA,05,3C → one `WrEn` cycle with `Address`=5, `WrData`=0x3C; return to IDLE; `Cmd_error`=0.
- Frame BB,07 → `RdEn` pulse with `Address`=7. `Rd_valid` 4 cycles later → IDLE. A byte sent during the wait pulses `Cmd_error`.
- Frame CC,12,34,01 → writes 0x12@0 and 0x34@1, then `ALU_FUN`=1 and an `ALU_EN` pulse. `Gate_EN` stays high from the edge after byte 34 until the edge after `ALU_out_valid`.
- Byte 0x55 in IDLE → single `Cmd_error` pulse, no other output activity.
- Frame DD,02 with no `ALU_out_valid` → `Cmd_error` after `WAIT_MAX` cycles, `Gate_EN` drops, IDLE.
- Frame AA,05 then `Reset`=0 for one cycle, then AA,06,FF → no write for address 5; single write 0xFF@6.
